// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight, applies decode's redirects and fills the IF_ID register
// with {PC+4, instruction} or a bubble {next PC+4, NOP}.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC  = 32'h8000_0004,
    parameter logic [31:0] XADR_PC   = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        PC_IF_ID_Write,
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic        interrupt,
    input  logic        exception,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] PC,
    output logic [63:0] IF_ID
);

    typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [63:0] if_id_q, if_id_n;
    logic [31:0] skid_q, skid_n;

    logic        hold;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;
    logic [63:0] redir_bubble;
    logic [63:0] seq_bubble;

    // Sequential increment keeps the supervisor bit; only the low 31 bits wrap.
    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    // Redirect arbitration: traps beat the stall, the stall masks control flow.
    always_comb begin
        hold  = ~PC_IF_ID_Write;
        redir = 1'b1;
        tgt   = pc_q;
        if (exception)
            tgt = XADR_PC;
        else if (interrupt)
            tgt = ILLOP_PC;
        else if (hold)
            redir = 1'b0;
        else if (JR)
            tgt = jr_target;
        else if (J)
            tgt = jump_target;
        else if (Z)
            tgt = branch_target;
        else
            redir = 1'b0;
    end

    // Bubbles carry the resume address + 4 so decode can recover it.
    assign pc_plus4     = pc_inc(pc_q);
    assign redir_bubble = {pc_inc(tgt), NOP_INSTR};
    assign seq_bubble   = {pc_plus4, NOP_INSTR};

    // Next-state, next-PC and IF_ID selection for the fetch FSM.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        if_id_n = if_id_q;
        skid_n  = skid_q;
        case (state)
            REQ: begin
                if (redir) begin
                    pc_n    = tgt;
                    if_id_n = redir_bubble;
                end else begin
                    state_n = WAIT;
                    if (!hold) if_id_n = seq_bubble;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    state_n = REQ;
                    if (redir) begin
                        pc_n    = tgt;
                        if_id_n = redir_bubble;
                    end else if (hold) begin
                        skid_n  = imem_rdata;
                        state_n = HOLD;
                    end else begin
                        pc_n    = pc_plus4;
                        if_id_n = {pc_plus4, imem_rdata};
                    end
                end else if (redir) begin
                    pc_n    = tgt;
                    if_id_n = redir_bubble;
                    state_n = DROP;
                end else if (!hold) begin
                    if_id_n = seq_bubble;
                end
            end
            DROP: begin
                // The in-flight response belongs to a squashed path.
                if (redir) begin
                    pc_n    = tgt;
                    if_id_n = redir_bubble;
                end
                if (imem_ready) state_n = REQ;
            end
            HOLD: begin
                if (redir) begin
                    pc_n    = tgt;
                    if_id_n = redir_bubble;
                    state_n = REQ;
                end else if (!hold) begin
                    pc_n    = pc_plus4;
                    if_id_n = {pc_plus4, skid_q};
                    state_n = REQ;
                end
            end
            default: state_n = REQ;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= REQ;
            pc_q    <= RESET_PC;
            if_id_q <= 64'd0;
            skid_q  <= 32'd0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            if_id_q <= if_id_n;
            skid_q  <= skid_n;
        end
    end

    assign imem_req  = (state == REQ) && !reset;
    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign IF_ID     = if_id_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: redirect-priority vector table, hand-written multi-cycle
// sequences, then randomized traffic against a transaction-level model.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] XADR_PC  = 32'h8000_0008;
    localparam logic [31:0] BR_T     = 32'h0000_0040;
    localparam logic [31:0] JMP_T    = 32'h1234_5670;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        PC_IF_ID_Write = 1'b1;
    logic        Z = 1'b0, J = 1'b0, JR = 1'b0, interrupt = 1'b0, exception = 1'b0;
    logic [31:0] branch_target = BR_T, jump_target = JMP_T, jr_target = 32'd0;
    logic [31:0] PC;
    logic [63:0] IF_ID;

    if_fetch dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .PC_IF_ID_Write(PC_IF_ID_Write),
        .Z(Z), .J(J), .JR(JR), .interrupt(interrupt), .exception(exception),
        .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
        .PC(PC), .IF_ID(IF_ID)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // memory responder: one pending slot, a newer request replaces it
    bit          mem_pend = 0;
    int          mem_cnt = 0;
    int          mem_lat = 0;
    logic [31:0] mem_addr = 32'd0;

    // reference model state
    logic [31:0] m_pc, m_ifid_pc4, m_ifid_ins;
    bit          m_busy, m_stale;
    logic [31:0] m_skid[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h2008_0001;
        return {a[15:0], ~a[31:16]};
    endfunction

    // supervisor bit kept, lower 31 bits advance by four
    function automatic logic [31:0] next_seq(input logic [31:0] a);
        return ((a + 32'd4) & 32'h7FFF_FFFF) | (a & 32'h8000_0000);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        PC_IF_ID_Write = 1'b1;
        Z = 0; J = 0; JR = 0; interrupt = 0; exception = 0;
    endtask

    task automatic m_redirect(input logic [31:0] t);
        m_pc       = t;
        m_ifid_pc4 = next_seq(t);
        m_ifid_ins = 32'd0;
    endtask

    // One clock: drive memory response, check request, advance model, check state.
    task automatic step();
        logic        hold, rd, m_req;
        logic [31:0] t;
        imem_ready = mem_pend && (mem_cnt == 0);
        imem_rdata = imem_ready ? mem_word(mem_addr) : $urandom;
        #1;
        m_req = !reset && !m_busy && (m_skid.size() == 0);
        chk("imem_req", 64'(imem_req), 64'(m_req));
        if (m_req) chk("imem_addr", 64'(imem_addr), 64'(m_pc));

        if (reset) mem_pend = 0;
        else begin
            if (imem_ready) mem_pend = 0;
            else if (mem_pend) mem_cnt--;
            if (imem_req) begin
                mem_pend = 1;
                mem_cnt  = mem_lat;
                mem_addr = imem_addr;
            end
        end

        hold = !PC_IF_ID_Write;
        rd   = 1;
        t    = m_pc;
        if (exception)        t = XADR_PC;
        else if (interrupt)   t = ILLOP_PC;
        else if (!hold && JR) t = jr_target;
        else if (!hold && J)  t = jump_target;
        else if (!hold && Z)  t = branch_target;
        else                  rd = 0;

        if (reset) begin
            m_pc = RESET_PC; m_ifid_pc4 = 0; m_ifid_ins = 0;
            m_busy = 0; m_stale = 0; m_skid.delete();
        end else if (m_skid.size() != 0) begin
            if (rd) begin
                m_skid.delete();
                m_redirect(t);
            end else if (!hold) begin
                m_ifid_pc4 = next_seq(m_pc);
                m_ifid_ins = m_skid.pop_front();
                m_pc       = next_seq(m_pc);
            end
        end else if (!m_busy) begin
            if (rd) m_redirect(t);
            else begin
                m_busy = 1; m_stale = 0;
                if (!hold) begin m_ifid_pc4 = next_seq(m_pc); m_ifid_ins = 0; end
            end
        end else if (imem_ready) begin
            m_busy = 0;
            if (rd) m_redirect(t);
            else if (!m_stale) begin
                if (hold) m_skid.push_back(imem_rdata);
                else begin
                    m_ifid_pc4 = next_seq(m_pc);
                    m_ifid_ins = imem_rdata;
                    m_pc       = next_seq(m_pc);
                end
            end
            m_stale = 0;
        end else begin
            if (rd) begin m_redirect(t); m_stale = 1; end
            else if (!m_stale && !hold) begin m_ifid_pc4 = next_seq(m_pc); m_ifid_ins = 0; end
        end

        @(posedge clk); #1;
        chk("model_pc", 64'(PC), 64'(m_pc));
        chk("model_if_id", IF_ID, {m_ifid_pc4, m_ifid_ins});
    endtask

    task automatic do_reset();
        idle();
        reset = 1; step();
        reset = 0;
    endtask

    typedef struct {
        string       name;
        logic        exc, intr, wr, jr, j, z;
        logic [31:0] jr_t;
        logic [31:0] exp_pc;
        logic [63:0] exp_ifid;
    } vec_t;

    function automatic vec_t mk(input string n, input logic e, input logic i, input logic w,
                                input logic r, input logic jj, input logic zz,
                                input logic [31:0] jt, input logic [31:0] epc, input logic [63:0] eif);
        vec_t v;
        v.name = n; v.exc = e; v.intr = i; v.wr = w; v.jr = r; v.j = jj; v.z = zz;
        v.jr_t = jt; v.exp_pc = epc; v.exp_ifid = eif;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        // first cycle out of reset, from state REQ with IF_ID = 0
        vecs[0]  = mk("v_idle",      0,0,1,0,0,0, 32'h0,         32'h8000_0000, {32'h8000_0004, 32'h0});
        vecs[1]  = mk("v_exc_int",   1,1,1,0,0,0, 32'h0,         32'h8000_0008, {32'h8000_000C, 32'h0});
        vecs[2]  = mk("v_int",       0,1,1,0,0,0, 32'h0,         32'h8000_0004, {32'h8000_0008, 32'h0});
        vecs[3]  = mk("v_hold_ctl",  0,0,0,1,1,1, 32'h0040_0010, 32'h8000_0000, 64'h0);
        vecs[4]  = mk("v_hold_int",  0,1,0,0,0,0, 32'h0,         32'h8000_0004, {32'h8000_0008, 32'h0});
        vecs[5]  = mk("v_jr_j_z",    0,0,1,1,1,1, 32'h0040_0010, 32'h0040_0010, {32'h0040_0014, 32'h0});
        vecs[6]  = mk("v_j_z",       0,0,1,0,1,1, 32'h0,         JMP_T,         {32'h1234_5674, 32'h0});
        vecs[7]  = mk("v_z",         0,0,1,0,0,1, 32'h0,         BR_T,          {32'h0000_0044, 32'h0});
        vecs[8]  = mk("v_hold_exc",  1,0,0,0,1,0, 32'h0,         32'h8000_0008, {32'h8000_000C, 32'h0});
        vecs[9]  = mk("v_wrap_user", 0,0,1,1,0,0, 32'h7FFF_FFFC, 32'h7FFF_FFFC, {32'h0000_0000, 32'h0});
        vecs[10] = mk("v_wrap_sup",  0,0,1,1,0,0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, {32'h8000_0000, 32'h0});
        vecs[11] = mk("v_all",       1,1,0,1,1,1, 32'h0040_0010, 32'h8000_0008, {32'h8000_000C, 32'h0});

        mem_lat = 0;
        for (int k = 0; k < 12; k++) begin
            do_reset();
            chk("reset_pc", 64'(PC), 64'(RESET_PC));
            chk("reset_if_id", IF_ID, 64'h0);
            exception = vecs[k].exc; interrupt = vecs[k].intr;
            PC_IF_ID_Write = vecs[k].wr;
            JR = vecs[k].jr; J = vecs[k].j; Z = vecs[k].z;
            jr_target = vecs[k].jr_t;
            step();
            chk({vecs[k].name, "_pc"}, 64'(PC), 64'(vecs[k].exp_pc));
            chk({vecs[k].name, "_if_id"}, IF_ID, vecs[k].exp_ifid);
        end
        idle();

        // zero-wait first fetch: instruction lands two edges after release
        mem_lat = 0; do_reset();
        step();
        chk("zw_pc1", 64'(PC), 64'(32'h8000_0000));
        chk("zw_if1", IF_ID, {32'h8000_0004, 32'h0});
        step();
        chk("zw_pc2", 64'(PC), 64'(32'h8000_0004));
        chk("zw_if2", IF_ID, {32'h8000_0004, 32'h2008_0001});
        chk("zw_req_again", 64'(imem_req), 64'd1);

        // three wait cycles: bubbles, PC stays, then one instruction
        mem_lat = 3; do_reset();
        step();
        for (int w = 0; w < 3; w++) begin
            step();
            chk("w3_pc_hold", 64'(PC), 64'(32'h8000_0000));
            chk("w3_bubble", IF_ID, {32'h8000_0004, 32'h0});
        end
        step();
        chk("w3_if", IF_ID, {32'h8000_0004, 32'h2008_0001});
        chk("w3_pc", 64'(PC), 64'(32'h8000_0004));

        // branch while waiting: stale response dropped, refetch from target
        mem_lat = 3; do_reset();
        step();
        Z = 1; branch_target = BR_T; step(); idle();
        chk("drop_pc", 64'(PC), 64'(BR_T));
        chk("drop_if", IF_ID, {32'h0000_0044, 32'h0});
        step(); step(); step();
        chk("drop_if_kept", IF_ID, {32'h0000_0044, 32'h0});
        chk("drop_req", 64'(imem_req), 64'd1);
        chk("drop_addr", 64'(imem_addr), 64'(BR_T));
        mem_lat = 0; step(); step();
        chk("drop_fetch", IF_ID, {32'h0000_0044, mem_word(BR_T)});

        // stall across the response with J asserted, then release
        mem_lat = 2; do_reset();
        step(); step(); step();
        PC_IF_ID_Write = 0; J = 1; jump_target = JMP_T;
        step();
        chk("hold_if_a", IF_ID, {32'h8000_0004, 32'h0});
        step();
        chk("hold_if_b", IF_ID, {32'h8000_0004, 32'h0});
        chk("hold_pc", 64'(PC), 64'(32'h8000_0000));
        idle(); step();
        chk("hold_rel_if", IF_ID, {32'h8000_0004, 32'h2008_0001});
        chk("hold_rel_pc", 64'(PC), 64'(32'h8000_0004));
        // interrupt while holding discards the skid
        mem_lat = 0; step();
        PC_IF_ID_Write = 0; step();
        interrupt = 1; step(); idle();
        chk("hold_int_pc", 64'(PC), 64'(ILLOP_PC));
        chk("hold_int_if", IF_ID, {32'h8000_0008, 32'h0});
        chk("hold_int_req", 64'(imem_req), 64'd1);

        // JR into user space: bit 31 stays clear across increments
        mem_lat = 0; do_reset();
        J = 1; jump_target = 32'h8000_0100; step(); idle();
        JR = 1; jr_target = 32'h0040_0010; step(); idle();
        chk("jr_pc", 64'(PC), 64'(32'h0040_0010));
        step(); step();
        chk("jr_inc1", 64'(PC), 64'(32'h0040_0014));
        step(); step();
        chk("jr_inc2", 64'(PC), 64'(32'h0040_0018));
        jump_target = JMP_T;

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset          = ($urandom_range(0, 99) == 0);
            PC_IF_ID_Write = ($urandom_range(0, 3) != 0);
            exception      = ($urandom_range(0, 29) == 0);
            interrupt      = ($urandom_range(0, 29) == 0);
            JR             = ($urandom_range(0, 11) == 0);
            J              = ($urandom_range(0, 11) == 0);
            Z              = ($urandom_range(0, 11) == 0);
            branch_target  = $urandom & 32'hFFFF_FFFC;
            jump_target    = $urandom & 32'hFFFF_FFFC;
            jr_target      = $urandom & 32'hFFFF_FFFC;
            mem_lat        = int'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. It sits directly upstream of the decode stage and produces the 64-bit IF_ID register: {PC+4, instruction}.
- It owns the PC and issues single-outstanding requests to the instruction memory.
- It applies the redirects resolved in decode: branch, jump, jump-register, interrupt and exception.
- It honours decode's load-use stall and inserts bubbles for every redirect and memory wait.

Parameters:
RESET_PC  32'h8000_0000  PC after reset (supervisor bit set)
ILLOP_PC  32'h8000_0004  interrupt vector
XADR_PC   32'h8000_0008  exception (undefined instruction) vector
NOP_INSTR 32'h0000_0000  instruction word inserted as a bubble

Ports:
clk            in   1   clock
reset          in   1   synchronous, active-high reset
imem_req       out  1   one-cycle request pulse; address valid in the same cycle
imem_addr      out  32  fetch address; equals PC
imem_ready     in   1   response valid for the single outstanding request
imem_rdata     in   32  instruction word, valid when imem_ready=1
PC_IF_ID_Write in   1   from decode; 0 = hold both PC and IF_ID (load-use stall)
Z              in   1   branch taken
J              in   1   jump
JR             in   1   jump register
interrupt      in   1   interrupt accepted by decode
exception      in   1   undefined instruction trapped by decode
branch_target  in   32  branch target
jump_target    in   32  jump target
jr_target      in   32  jump-register target
PC             out  32  current fetch PC
IF_ID          out  64  [63:32] = PC+4, [31:0] = instruction

Behaviour:
- Reset (clk edge with reset=1): PC = RESET_PC, IF_ID = 0, state = REQ, imem_req = 0 during reset. Reset mid-operation discards any outstanding response.
- Sequential increment: PC+4 = {PC[31], PC[30:0]+4}; the supervisor bit is preserved.
- Redirect priority, evaluated every cycle:
  - exception -> XADR_PC
  - interrupt -> ILLOP_PC
  - hold (PC_IF_ID_Write=0): Z, J and JR are ignored
  - JR -> jr_target
  - J -> jump_target
  - Z -> branch_target
- exception and interrupt override hold.
- "redir" = any redirect that wins under these rules.
- Bubble: IF_ID = {next PC + 4, NOP_INSTR}, so that decode's PC+4-4 equals the resume address.
- FSM states: REQ, WAIT, DROP, HOLD. Exactly one memory request is outstanding at most.
  - REQ: imem_req=1 with imem_addr=PC. If redir: PC <= target, IF_ID <= bubble, stay REQ. Otherwise go to WAIT. IF_ID <= bubble unless hold, in which case IF_ID keeps its value.
  - WAIT, imem_ready=1:
    - redir: discard data, PC <= target, IF_ID <= bubble, go to REQ.
    - hold: buffer imem_rdata in the skid register, go to HOLD; IF_ID unchanged.
    - else: IF_ID <= {PC+4, imem_rdata}, PC <= PC+4, go to REQ.
  - WAIT, imem_ready=0: if redir, PC <= target, IF_ID <= bubble, go to DROP. Otherwise IF_ID <= bubble, or is held if hold.
  - DROP: waiting to discard the stale response. A redir updates PC again and issues a bubble. On imem_ready, discard the data and go to REQ.
  - HOLD: while hold, everything is frozen. When hold drops: IF_ID <= {PC+4, skid}, PC <= PC+4, go to REQ. A redir (interrupt or exception) discards the skid, PC <= target, IF_ID <= bubble, go to REQ.
- Throughput: 2 cycles per instruction with a zero-wait memory (ready in the cycle after the request).
- imem_ready outside WAIT/DROP is ignored.
- Simultaneous J and Z: J wins. Simultaneous exception and interrupt: the exception vector is taken.

Test Plan:
- Reset, then zero-wait memory returning 0x2008_0001 for address 0x8000_0000 -> IF_ID = {0x8000_0004, 0x2008_0001} two edges after reset release; PC = 0x8000_0004; imem_req pulses every second cycle.
- Straight-line fetch with 3 wait cycles -> IF_ID carries bubbles {PC+4, 0} during the wait; PC holds; one instruction is delivered per response.
- Z=1 with branch_target=0x0000_0040 during WAIT, response pending -> state DROP; the stale response is discarded; the next request goes to 0x0000_0040; IF_ID = bubble {0x0000_0044, 0}.
- PC_IF_ID_Write=0 for 2 cycles while a response arrives with J=1 -> J is ignored, the data is held in skid, IF_ID is unchanged; on release IF_ID gets the skid instruction and PC advances by 4.
- interrupt=1 while in HOLD -> PC = 0x8000_0004, skid discarded, IF_ID = {0x8000_0008, 0}.
- exception and interrupt both asserted in REQ; separately, jr_target=0x0040_0010 from PC 0x8000_0100 -> exception case gives PC = 0x8000_0008; JR case gives PC = 0x0040_0010 with bit 31 cleared, and subsequent increments keep bit 31 = 0.
